// File: rtl/ds_width_reducer.sv
// ds_width_reducer: splits each OWIDTH*FACTOR-bit inbound word into FACTOR
// OWIDTH-bit outbound words, least-significant slice first, at one narrow
// word per clock with no bubbles between consecutive wide words.
module ds_width_reducer #(
  parameter int OWIDTH = 8,
  parameter int FACTOR = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [OWIDTH*FACTOR-1:0] i_dat,
  input  logic                     i_val,
  output logic                     i_rdy,
  output logic [OWIDTH-1:0]        o_dat,
  output logic                     o_val,
  input  logic                     o_rdy
);

  localparam int IWIDTH = OWIDTH * FACTOR;
  localparam int CNT_W  = $clog2(FACTOR);
  localparam logic [CNT_W-1:0] CNT_PENULT = CNT_W'(FACTOR - 2);

  logic [IWIDTH-1:0] data_reg;
  logic              busy_reg;
  logic [CNT_W-1:0]  slice_cnt;
  logic              last_reg;

  logic accept;
  logic deliver;

  // A new word can enter when idle, or when the final slice leaves this cycle.
  assign i_rdy   = ~busy_reg | (last_reg & o_rdy);
  assign accept  = i_val & i_rdy;
  assign deliver = busy_reg & o_rdy;

  // The low slice of the shifting register is the output, so no wide mux.
  assign o_val = busy_reg;
  assign o_dat = data_reg[OWIDTH-1:0];

  // Load on accept (wins over last-slice retire), otherwise shift per delivery.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_reg  <= '0;
      busy_reg  <= 1'b0;
      slice_cnt <= '0;
      last_reg  <= 1'b0;
    end else if (accept) begin
      data_reg  <= i_dat;
      busy_reg  <= 1'b1;
      slice_cnt <= '0;
      last_reg  <= 1'b0;
    end else if (deliver) begin
      if (last_reg) begin
        busy_reg  <= 1'b0;
        slice_cnt <= '0;
        last_reg  <= 1'b0;
      end else begin
        data_reg  <= data_reg >> OWIDTH;
        slice_cnt <= slice_cnt + CNT_W'(1);
        last_reg  <= (slice_cnt == CNT_PENULT);
      end
    end
  end

endmodule

// File: tb/tb_ds_width_reducer.sv
// Testbench for ds_width_reducer: directed vector table on an 8x4 instance,
// an asynchronous mid-word reset sequence, and a randomized run on a 4x3
// instance checked against a queue-of-slices reference model.
module tb_ds_width_reducer;

  logic clk = 1'b0;
  logic reset = 1'b1;

  // OWIDTH=8, FACTOR=4 instance
  logic [31:0] i_dat4;
  logic        i_val4;
  logic        i_rdy4;
  logic [7:0]  o_dat4;
  logic        o_val4;
  logic        o_rdy4;

  // OWIDTH=4, FACTOR=3 instance
  logic [11:0] i_dat3;
  logic        i_val3;
  logic        i_rdy3;
  logic [3:0]  o_dat3;
  logic        o_val3;
  logic        o_rdy3;

  int n_vec = 0;
  int n_err = 0;

  ds_width_reducer #(.OWIDTH(8), .FACTOR(4)) dut4 (
    .clk(clk), .reset(reset),
    .i_dat(i_dat4), .i_val(i_val4), .i_rdy(i_rdy4),
    .o_dat(o_dat4), .o_val(o_val4), .o_rdy(o_rdy4)
  );

  ds_width_reducer #(.OWIDTH(4), .FACTOR(3)) dut3 (
    .clk(clk), .reset(reset),
    .i_dat(i_dat3), .i_val(i_val3), .i_rdy(i_rdy3),
    .o_dat(o_dat3), .o_val(o_val3), .o_rdy(o_rdy3)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        i_val;
    logic [31:0] i_dat;
    logic        o_rdy;
    logic        exp_i_rdy;
    logic        exp_o_val;
    logic [7:0]  exp_o_dat;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic iv, input logic [31:0] d, input logic orr,
                     input logic eir, input logic eov, input logic [7:0] eod);
    vec_t v;
    v.i_val = iv; v.i_dat = d; v.o_rdy = orr;
    v.exp_i_rdy = eir; v.exp_o_val = eov; v.exp_o_dat = eod;
    tbl.push_back(v);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [11:0] words3 [2];
    logic [3:0]  q3 [$];
    logic [11:0] w;
    logic        took_in, took_out;
    int          forced;
    int          budget;

    i_dat4 = '0; i_val4 = 1'b0; o_rdy4 = 1'b0;
    i_dat3 = '0; i_val3 = 1'b0; o_rdy3 = 1'b0;

    // Reset state while reset is held.
    #2;
    check("reset_o_val", {31'b0, o_val4}, 32'd0);
    check("reset_i_rdy", {31'b0, i_rdy4}, 32'd1);
    check("reset_o_dat", {24'b0, o_dat4}, 32'd0);
    check("reset_o_val3", {31'b0, o_val3}, 32'd0);
    step();
    step();
    reset = 1'b0;
    #1;
    check("post_reset_i_rdy", {31'b0, i_rdy4}, 32'd1);

    // Single word, o_rdy=1.
    add(1, 32'h44332211, 1, 1, 0, 8'h00);
    add(0, 32'h0,        1, 0, 1, 8'h11);
    add(0, 32'h0,        1, 0, 1, 8'h22);
    add(0, 32'h0,        1, 0, 1, 8'h33);
    add(0, 32'h0,        1, 1, 1, 8'h44);
    add(0, 32'h0,        1, 1, 0, 8'h00);
    // Back-to-back words with i_val held.
    add(1, 32'h44332211, 1, 1, 0, 8'h00);
    add(1, 32'h88776655, 1, 0, 1, 8'h11);
    add(1, 32'h88776655, 1, 0, 1, 8'h22);
    add(1, 32'h88776655, 1, 0, 1, 8'h33);
    add(1, 32'h88776655, 1, 1, 1, 8'h44);
    add(0, 32'h0,        1, 0, 1, 8'h55);
    add(0, 32'h0,        1, 0, 1, 8'h66);
    add(0, 32'h0,        1, 0, 1, 8'h77);
    add(0, 32'h0,        1, 1, 1, 8'h88);
    add(0, 32'h0,        1, 1, 0, 8'h00);
    // Back-pressure on 0x22, i_dat wiggled while not ready.
    add(1, 32'h44332211, 1, 1, 0, 8'h00);
    add(0, 32'h0,        1, 0, 1, 8'h11);
    add(0, 32'h0,        0, 0, 1, 8'h22);
    add(0, 32'h0,        0, 0, 1, 8'h22);
    add(1, 32'hDEADBEEF, 0, 0, 1, 8'h22);
    add(1, 32'hDEADBEEF, 1, 0, 1, 8'h22);
    add(0, 32'h0,        1, 0, 1, 8'h33);
    add(0, 32'h0,        0, 0, 1, 8'h44);
    add(0, 32'h0,        1, 1, 1, 8'h44);
    add(0, 32'h0,        1, 1, 0, 8'h00);

    foreach (tbl[k]) begin
      i_val4 = tbl[k].i_val;
      i_dat4 = tbl[k].i_dat;
      o_rdy4 = tbl[k].o_rdy;
      #1;
      check($sformatf("row%0d_i_rdy", k), {31'b0, i_rdy4}, {31'b0, tbl[k].exp_i_rdy});
      check($sformatf("row%0d_o_val", k), {31'b0, o_val4}, {31'b0, tbl[k].exp_o_val});
      if (tbl[k].exp_o_val)
        check($sformatf("row%0d_o_dat", k), {24'b0, o_dat4}, {24'b0, tbl[k].exp_o_dat});
      step();
    end

    // Reset mid-word after 0x22 is delivered.
    i_val4 = 1'b1; i_dat4 = 32'h44332211; o_rdy4 = 1'b1;
    step();
    i_val4 = 1'b0;
    step();
    step();
    check("pre_reset_o_dat", {24'b0, o_dat4}, 32'h33);
    #2;
    reset = 1'b1;
    #1;
    check("midreset_o_val", {31'b0, o_val4}, 32'd0);
    check("midreset_i_rdy", {31'b0, i_rdy4}, 32'd1);
    check("midreset_o_dat", {24'b0, o_dat4}, 32'd0);
    step();
    reset = 1'b0;
    #1;
    check("after_reset_o_val", {31'b0, o_val4}, 32'd0);
    check("after_reset_i_rdy", {31'b0, i_rdy4}, 32'd1);
    i_val4 = 1'b1; i_dat4 = 32'hDDCCBBAA;
    step();
    i_val4 = 1'b0;
    for (int s = 0; s < 4; s++) begin
      logic [31:0] ew;
      ew = 32'hDDCCBBAA;
      #1;
      check($sformatf("rst_seq%0d_o_val", s), {31'b0, o_val4}, 32'd1);
      check($sformatf("rst_seq%0d_o_dat", s), {24'b0, o_dat4}, {24'b0, ew[8*s +: 8]});
      step();
    end
    #1;
    check("rst_seq_end_o_val", {31'b0, o_val4}, 32'd0);
    check("rst_seq_end_i_rdy", {31'b0, i_rdy4}, 32'd1);
    o_rdy4 = 1'b0;

    // Randomized run on the FACTOR=3 instance against a slice queue.
    words3[0] = 12'h321;
    words3[1] = 12'h654;
    forced = 0;
    for (int c = 0; c < 600; c++) begin
      i_val3 = 1'($urandom_range(0, 1));
      o_rdy3 = 1'($urandom_range(0, 3) != 0);
      i_dat3 = (forced < 2) ? words3[forced] : 12'($urandom);
      #1;
      check("rnd_o_val", {31'b0, o_val3}, {31'b0, q3.size() != 0});
      check("rnd_i_rdy", {31'b0, i_rdy3},
            {31'b0, (q3.size() == 0) || (q3.size() == 1 && o_rdy3)});
      if (o_val3 && q3.size() != 0)
        check("rnd_o_dat", {28'b0, o_dat3}, {28'b0, q3[0]});
      check("rnd_cnt_bound", {31'b0, dut3.slice_cnt < 2'd3}, 32'd1);
      took_out = o_val3 & o_rdy3;
      took_in  = i_val3 & i_rdy3;
      w = i_dat3;
      step();
      if (took_out && q3.size() != 0) void'(q3.pop_front());
      if (took_in) begin
        for (int k = 0; k < 3; k++) q3.push_back(w[4*k +: 4]);
        if (forced < 2) forced++;
      end
    end

    // Drain the remaining slices with a bounded wait.
    i_val3 = 1'b0;
    o_rdy3 = 1'b1;
    budget = 10;
    while (q3.size() != 0 && budget > 0) begin
      #1;
      check("drain_o_dat", {28'b0, o_dat3}, {28'b0, q3[0]});
      step();
      void'(q3.pop_front());
      budget--;
    end
    #1;
    check("drain_done_o_val", {31'b0, o_val3}, 32'd0);
    check("first_words_taken", forced, 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
